// File: rtl/uncached_link_responder_if.sv
// UncachedLinkIO refill link: block acquire from the cache, beat-wise grant back.
// master = cache client, slave = memory-side responder.
interface uncached_link_responder_if #(
  parameter int ADDR_W = 32,
  parameter int BEAT_W = 64,
  parameter int BEATS  = 4
);
  localparam int IDX_W = $clog2(BEATS);

  // Both channels use strict valid/ready: a transfer happens on a rising edge
  // where valid && ready; a raised valid and its payload stay stable until then.
  logic              acquire_valid;
  logic              acquire_ready;
  logic [ADDR_W-1:0] acquire_addr;

  logic              grant_valid;
  logic              grant_ready;
  logic [BEAT_W-1:0] grant_data;
  logic [IDX_W-1:0]  grant_beat;
  logic              grant_last;
  logic              grant_error;

  modport master (
    output acquire_valid, acquire_addr, grant_ready,
    input  acquire_ready, grant_valid, grant_data, grant_beat, grant_last, grant_error
  );

  modport slave (
    input  acquire_valid, acquire_addr, grant_ready,
    output acquire_ready, grant_valid, grant_data, grant_beat, grant_last, grant_error
  );
endinterface

// File: rtl/uncached_link_responder.sv
// Memory-side refill responder: one block acquire at a time, streamed back as
// BEATS grant beats through a 2-entry skid FIFO. Optional: UNCACHED_RESP_RANGE_CHECK_EN.
module uncached_link_responder #(
  parameter int ADDR_W     = 32,
  parameter int BEAT_W     = 64,
  parameter int BEATS      = 4,
  parameter int MEM_BLOCKS = 1024
) (
  input  logic                              clk,
  input  logic                              rst_n,
  uncached_link_responder_if.slave          link,
  output logic                              mem_rd_en,
  output logic [ADDR_W+$clog2(BEATS)-1:0]   mem_rd_addr,
  input  logic [BEAT_W-1:0]                 mem_rd_data
);
  localparam int IDX_W = $clog2(BEATS);

  if (BEATS < 2 || (BEATS & (BEATS - 1)) != 0 || MEM_BLOCKS < 1) begin : g_bad_params
    $error("uncached_link_responder: BEATS must be a power of two >= 2, MEM_BLOCKS >= 1");
  end

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  typedef struct packed {
    logic [BEAT_W-1:0] data;
    logic [IDX_W-1:0]  beat;
    logic              err;
  } entry_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] blk_addr_q;
  logic [IDX_W:0]    read_idx_q;
  logic              err_blk_q;
  logic              inflight_q;
  logic [IDX_W-1:0]  inflight_beat_q;

  entry_t            fifo_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q;
  entry_t            head, push_entry;

  logic accept, deq, issue, err_push, push, range_err;
  logic reads_left, room;
  logic [2:0] occupancy;

`ifdef UNCACHED_RESP_RANGE_CHECK_EN
  assign range_err = {1'b0, link.acquire_addr} >= (ADDR_W + 1)'(MEM_BLOCKS);
`else
  assign range_err = 1'b0;
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_STREAM;
      S_STREAM: if (deq && link.grant_last) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // A read slot exists when the FIFO can still absorb everything already
  // requested, counting the beat leaving this cycle.
  assign occupancy  = {1'b0, count_q} + {2'b00, inflight_q};
  assign room       = occupancy < (3'd2 + {2'b00, deq});
  assign reads_left = read_idx_q < (IDX_W + 1)'(BEATS);

  always_comb begin
    link.acquire_ready = 1'b0;
    issue              = 1'b0;
    case (state_q)
      S_IDLE:   link.acquire_ready = rst_n;
      S_STREAM: issue = reads_left && room;
      default:  ;
    endcase
  end

  assign accept      = link.acquire_valid && link.acquire_ready;
  assign deq         = link.grant_valid && link.grant_ready;
  assign mem_rd_en   = issue && !err_blk_q;
  assign mem_rd_addr = mem_rd_en ? {blk_addr_q, read_idx_q[IDX_W-1:0]} : '0;

  // Error blocks bypass memory: each slot pushes a zero beat straight away,
  // which is why their first grant appears one cycle earlier.
  assign err_push = issue && err_blk_q;
  assign push     = inflight_q || err_push;

  always_comb begin
    push_entry = '0;
    if (err_push) begin
      push_entry.beat = read_idx_q[IDX_W-1:0];
      push_entry.err  = 1'b1;
    end else begin
      push_entry.data = mem_rd_data;
      push_entry.beat = inflight_beat_q;
    end
  end

  // ---------------- request tracking ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_addr_q      <= '0;
      read_idx_q      <= '0;
      err_blk_q       <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_beat_q <= '0;
    end else begin
      if (accept) begin
        blk_addr_q <= link.acquire_addr;
        read_idx_q <= '0;
        err_blk_q  <= range_err;
      end else if (issue) begin
        read_idx_q <= read_idx_q + 1'b1;
      end
      inflight_q      <= mem_rd_en;
      inflight_beat_q <= read_idx_q[IDX_W-1:0];
    end
  end

  // ---------------- skid FIFO ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= push_entry;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (deq) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, deq};
    end
  end

  // ---------------- grant outputs ----------------
  // Payload is forced to zero while idle so stale entries never leak out.
  assign head             = fifo_q[rd_ptr_q];
  assign link.grant_valid = count_q != 2'd0;
  assign link.grant_data  = link.grant_valid ? head.data : '0;
  assign link.grant_beat  = link.grant_valid ? head.beat : '0;
  assign link.grant_last  = link.grant_valid && (head.beat == IDX_W'(BEATS - 1));
`ifdef UNCACHED_RESP_RANGE_CHECK_EN
  assign link.grant_error = link.grant_valid && head.err;
`else
  assign link.grant_error = 1'b0;
`endif
endmodule

// File: tb/tb_uncached_link_responder.sv
// Directed bench for uncached_link_responder: latency, stall, back-to-back,
// mid-block reset and (when enabled) the out-of-range error path.
module tb_uncached_link_responder;
  localparam int ADDR_W     = 32;
  localparam int BEAT_W     = 64;
  localparam int BEATS      = 4;
  localparam int MEM_BLOCKS = 1024;
  localparam int RD_AW      = ADDR_W + 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uncached_link_responder_if #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .BEATS(BEATS)) link ();

  logic              mem_rd_en;
  logic [RD_AW-1:0]  mem_rd_addr;
  logic [BEAT_W-1:0] mem_rd_data = '0;

  uncached_link_responder #(
    .ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .BEATS(BEATS), .MEM_BLOCKS(MEM_BLOCKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .link(link),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
  );

  // Backing memory: pattern data equals the beat address, one-cycle read.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= BEAT_W'(mem_rd_addr);

  // ---------------- scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  int rd_count     = 0;
  logic [BEAT_W-1:0] exp_q[$];
  logic [BEAT_W-1:0] got_q[$];
  logic [1:0]        got_beat_q[$];
  logic              got_last_q[$];
  logic              got_err_q[$];

  always @(negedge clk) begin
    if (mem_rd_en) rd_count++;
    if (link.grant_valid && link.grant_ready) begin
      got_q.push_back(link.grant_data);
      got_beat_q.push_back(link.grant_beat);
      got_last_q.push_back(link.grant_last);
      got_err_q.push_back(link.grant_error);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_got();
    got_q.delete(); got_beat_q.delete(); got_last_q.delete(); got_err_q.delete();
    exp_q.delete();
  endtask

  task automatic send_acquire(input logic [ADDR_W-1:0] addr);
    link.acquire_addr  = addr;
    link.acquire_valid = 1'b1;
    tick();
    link.acquire_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    for (int c = 0; c < 60 && got_q.size() < n; c++) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    link.acquire_valid = 1'b0; link.acquire_addr = '0; link.grant_ready = 1'b0;
    tick(); tick();
    tests_run++; if (link.acquire_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_acquire_ready got=%0b exp=0", link.acquire_ready); end
    tests_run++; if (link.grant_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_grant_valid got=%0b exp=0", link.grant_valid); end
    tests_run++; if ({link.grant_last, link.grant_error} !== 2'b00) begin tests_failed++; $display("FAIL reset_last_err got=%b exp=00", {link.grant_last, link.grant_error}); end
    tests_run++; if (link.grant_beat !== 2'd0 || link.grant_data !== '0) begin tests_failed++; $display("FAIL reset_beat_data got=%0d/%h exp=0/0", link.grant_beat, link.grant_data); end
    tests_run++; if (mem_rd_en !== 1'b0 || mem_rd_addr !== '0) begin tests_failed++; $display("FAIL reset_mem got=%0b/%h exp=0/0", mem_rd_en, mem_rd_addr); end
    rst_n = 1'b1;
    #1;
    tests_run++; if (link.acquire_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_ready got=%0b exp=1", link.acquire_ready); end
    tick();
  endtask

  // Cycle-exact timeline of one block with grant_ready held high.
  task automatic test_single_latency();
    logic exp_rd, exp_gv, exp_last, exp_ar;
    logic [RD_AW-1:0]  exp_addr;
    logic [BEAT_W-1:0] exp_data;
    logic [1:0]        exp_beat;
    clear_got();
    link.grant_ready = 1'b1;
    send_acquire(32'h10);
    for (int k = 1; k <= 7; k++) begin
      exp_rd   = (k >= 1 && k <= 4);
      exp_addr = exp_rd ? RD_AW'(32'h40 + k - 1) : '0;
      exp_gv   = (k >= 3 && k <= 6);
      exp_data = exp_gv ? BEAT_W'(32'h40 + k - 3) : '0;
      exp_beat = exp_gv ? 2'(k - 3) : 2'd0;
      exp_last = (k == 6);
      exp_ar   = (k == 7);
      tests_run++; if (mem_rd_en !== exp_rd || mem_rd_addr !== exp_addr) begin tests_failed++; $display("FAIL single_read T+%0d got=%0b/%h exp=%0b/%h", k, mem_rd_en, mem_rd_addr, exp_rd, exp_addr); end
      tests_run++; if (link.grant_valid !== exp_gv || link.grant_data !== exp_data) begin tests_failed++; $display("FAIL single_grant T+%0d got=%0b/%h exp=%0b/%h", k, link.grant_valid, link.grant_data, exp_gv, exp_data); end
      tests_run++; if (link.grant_beat !== exp_beat || link.grant_last !== exp_last) begin tests_failed++; $display("FAIL single_beat_last T+%0d got=%0d/%0b exp=%0d/%0b", k, link.grant_beat, link.grant_last, exp_beat, exp_last); end
      tests_run++; if (link.acquire_ready !== exp_ar) begin tests_failed++; $display("FAIL single_acq_ready T+%0d got=%0b exp=%0b", k, link.acquire_ready, exp_ar); end
      tick();
    end
    clear_got();
  endtask

  task automatic test_stall();
    int r0;
    logic [BEAT_W-1:0] d;
    clear_got();
    r0 = rd_count;
    link.grant_ready = 1'b1;
    send_acquire(32'h10);
    for (int k = 1; k <= 7; k++) begin
      if (k == 3) link.grant_ready = 1'b0;
      #1;
      if (k >= 3) begin
        tests_run++; if (link.grant_valid !== 1'b1 || link.grant_data !== 64'h40 || link.grant_beat !== 2'd0) begin tests_failed++; $display("FAIL stall_hold T+%0d got=%0b/%h/%0d exp=1/40/0", k, link.grant_valid, link.grant_data, link.grant_beat); end
      end
      tick();
    end
    tests_run++; if (rd_count - r0 !== 2) begin tests_failed++; $display("FAIL stall_reads_before got=%0d exp=2", rd_count - r0); end
    link.grant_ready = 1'b1;
    wait_beats(4);
    tick(); tick();
    for (int i = 0; i < 4; i++) exp_q.push_back(BEAT_W'(32'h40 + i));
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (got_q.size() == 0) begin tests_failed++; $display("FAIL stall_beat%0d got=none exp=%h", i, exp_q[0]); exp_q.pop_front(); end
      else begin
        d = got_q.pop_front();
        if (d !== exp_q[0] || got_beat_q[0] !== 2'(i) || got_last_q[0] !== (i == 3)) begin
          tests_failed++; $display("FAIL stall_beat%0d got=%h/%0d/%0b exp=%h/%0d/%0b", i, d, got_beat_q[0], got_last_q[0], exp_q[0], i, (i == 3));
        end
        exp_q.pop_front(); got_beat_q.pop_front(); got_last_q.pop_front();
      end
    end
    tests_run++; if (got_q.size() != 0) begin tests_failed++; $display("FAIL stall_extra_beats got=%0d exp=0", got_q.size()); end
    tests_run++; if (rd_count - r0 !== 4) begin tests_failed++; $display("FAIL stall_reads_total got=%0d exp=4", rd_count - r0); end
    clear_got();
  endtask

  // Acquire held valid through the final beat: must be taken one cycle later.
  task automatic test_back_to_back();
    int acc, c_last, c_acc2;
    logic hs;
    logic [BEAT_W-1:0] d;
    clear_got();
    link.grant_ready   = 1'b1;
    link.acquire_addr  = 32'h10;
    link.acquire_valid = 1'b1;
    acc = 0; c_last = -1; c_acc2 = -1;
    for (int c = 0; c < 40 && acc < 2; c++) begin
      if (link.grant_valid && link.grant_last && c_last < 0) begin
        c_last = c;
        tests_run++; if (link.acquire_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_ready_on_last got=%0b exp=0", link.acquire_ready); end
      end
      hs = link.acquire_valid && link.acquire_ready;
      if (hs && acc == 1) c_acc2 = c;
      tick();
      if (hs) begin
        acc++;
        if (acc == 1) link.acquire_addr = 32'h11;
        else link.acquire_valid = 1'b0;
      end
    end
    link.acquire_valid = 1'b0;
    tests_run++; if (acc !== 2 || c_acc2 !== c_last + 1) begin tests_failed++; $display("FAIL b2b_second_accept got=acc%0d@%0d exp=acc2@%0d", acc, c_acc2, c_last + 1); end
    wait_beats(8);
    for (int i = 0; i < 8; i++) exp_q.push_back(BEAT_W'(32'h40 + i));
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (got_q.size() == 0) begin tests_failed++; $display("FAIL b2b_beat%0d got=none exp=%h", i, exp_q[0]); exp_q.pop_front(); end
      else begin
        d = got_q.pop_front();
        if (d !== exp_q[0] || got_beat_q[0] !== 2'(i % 4) || got_last_q[0] !== (i % 4 == 3)) begin
          tests_failed++; $display("FAIL b2b_beat%0d got=%h/%0d/%0b exp=%h/%0d/%0b", i, d, got_beat_q[0], got_last_q[0], exp_q[0], i % 4, (i % 4 == 3));
        end
        exp_q.pop_front(); got_beat_q.pop_front(); got_last_q.pop_front();
      end
    end
    tick(); tick();
    clear_got();
  endtask

  task automatic test_reset_mid_stream();
    logic [BEAT_W-1:0] d;
    clear_got();
    link.grant_ready = 1'b1;
    send_acquire(32'h10);
    for (int c = 0; c < 20 && got_q.size() < 2; c++) tick();
    tests_run++; if (got_q.size() != 2) begin tests_failed++; $display("FAIL rstmid_pre_beats got=%0d exp=2", got_q.size()); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (link.grant_valid !== 1'b0 || mem_rd_en !== 1'b0 || link.acquire_ready !== 1'b0) begin tests_failed++; $display("FAIL rstmid_async got=%0b/%0b/%0b exp=0/0/0", link.grant_valid, mem_rd_en, link.acquire_ready); end
    tick(); tick();
    rst_n = 1'b1;
    #1;
    tests_run++; if (link.acquire_ready !== 1'b1 || link.grant_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_release got=%0b/%0b exp=1/0", link.acquire_ready, link.grant_valid); end
    tick();
    clear_got();
    send_acquire(32'h20);
    wait_beats(4);
    for (int i = 0; i < 4; i++) exp_q.push_back(BEAT_W'(32'h80 + i));
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (got_q.size() == 0) begin tests_failed++; $display("FAIL rstmid_beat%0d got=none exp=%h", i, exp_q[0]); exp_q.pop_front(); end
      else begin
        d = got_q.pop_front();
        if (d !== exp_q[0] || got_beat_q[0] !== 2'(i)) begin tests_failed++; $display("FAIL rstmid_beat%0d got=%h/%0d exp=%h/%0d", i, d, got_beat_q[0], exp_q[0], i); end
        exp_q.pop_front(); got_beat_q.pop_front();
      end
    end
    tick(); tick();
    clear_got();
  endtask

  task automatic test_range();
    int r0;
    logic [BEAT_W-1:0] d;
    logic e;
    clear_got();
    link.grant_ready = 1'b1;
    r0 = rd_count;
    send_acquire(32'h400);
`ifdef UNCACHED_RESP_RANGE_CHECK_EN
    tests_run++; if (link.grant_valid !== 1'b0) begin tests_failed++; $display("FAIL range_t1_valid got=%0b exp=0", link.grant_valid); end
    tick();
    tests_run++; if (link.grant_valid !== 1'b1 || link.grant_error !== 1'b1) begin tests_failed++; $display("FAIL range_t2_valid_err got=%0b/%0b exp=1/1", link.grant_valid, link.grant_error); end
`endif
    wait_beats(4);
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
`ifdef UNCACHED_RESP_RANGE_CHECK_EN
      exp_q.push_back('0);
`else
      exp_q.push_back(BEAT_W'(32'h1000 + i));
`endif
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (got_q.size() == 0) begin tests_failed++; $display("FAIL range_beat%0d got=none exp=%h", i, exp_q[0]); exp_q.pop_front(); end
      else begin
        d = got_q.pop_front(); e = got_err_q.pop_front();
`ifdef UNCACHED_RESP_RANGE_CHECK_EN
        if (d !== exp_q[0] || e !== 1'b1 || got_beat_q[0] !== 2'(i) || got_last_q[0] !== (i == 3)) begin tests_failed++; $display("FAIL range_beat%0d got=%h/err%0b exp=%h/err1", i, d, e, exp_q[0]); end
`else
        if (d !== exp_q[0] || e !== 1'b0 || got_beat_q[0] !== 2'(i) || got_last_q[0] !== (i == 3)) begin tests_failed++; $display("FAIL range_beat%0d got=%h/err%0b exp=%h/err0", i, d, e, exp_q[0]); end
`endif
        exp_q.pop_front(); got_beat_q.pop_front(); got_last_q.pop_front();
      end
    end
`ifdef UNCACHED_RESP_RANGE_CHECK_EN
    tests_run++; if (rd_count - r0 !== 0) begin tests_failed++; $display("FAIL range_no_reads got=%0d exp=0", rd_count - r0); end
`else
    tests_run++; if (rd_count - r0 !== 4) begin tests_failed++; $display("FAIL range_reads got=%0d exp=4", rd_count - r0); end
`endif
    clear_got();
    r0 = rd_count;
    send_acquire(32'h3FF);
    wait_beats(4);
    tick(); tick();
    for (int i = 0; i < 4; i++) exp_q.push_back(BEAT_W'(32'hFFC + i));
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (got_q.size() == 0) begin tests_failed++; $display("FAIL inrange_beat%0d got=none exp=%h", i, exp_q[0]); exp_q.pop_front(); end
      else begin
        d = got_q.pop_front(); e = got_err_q.pop_front();
        if (d !== exp_q[0] || e !== 1'b0) begin tests_failed++; $display("FAIL inrange_beat%0d got=%h/err%0b exp=%h/err0", i, d, e, exp_q[0]); end
        exp_q.pop_front();
      end
    end
    tests_run++; if (rd_count - r0 !== 4) begin tests_failed++; $display("FAIL inrange_reads got=%0d exp=4", rd_count - r0); end
    clear_got();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_latency();
    test_stall();
    test_back_to_back();
    test_reset_mid_stream();
    test_range();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
